// File: rtl/parity_stream.sv
// parity_stream: computes the XOR parity of a packet of DATA_W-bit beats.
// A packet ends on the beat marked in_last. The result is held until it is consumed.
//
// Parameters
//   DATA_W : beat width (>=1)
//   ODD    : 0 = even parity, 1 = odd parity
//   CNT_W  : width of the saturating mismatch counter (>=1)
//
// Ports
//   clk, rst_n          : rising-edge clock, async active-low reset
//   in_valid/in_ready   : beat handshake; a beat is taken when both are 1 at an edge
//   in_data, in_last    : beat payload and end-of-packet marker
//   in_par, chk_en      : expected parity and check enable, used only on the last beat
//   out_valid/out_ready : result handshake
//   out_par, out_err    : packet parity and mismatch flag, held while out_valid=0
//   err_cnt, clr_cnt    : saturating mismatch count and its synchronous clear
module parity_stream #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_par,
  input  logic              chk_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_par,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              clr_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic ODD_BIT = (ODD != 0);

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic             out_par_q, out_par_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic beat_par;
  logic accept;
  logic pkt_par;
  logic pkt_err;

  // In HOLD the upstream can only advance when the pending result is consumed.
  assign in_ready = (state_q == HOLD) ? out_ready : 1'b1;

  always_comb begin
    beat_par = ^in_data;
    accept   = in_valid & in_ready;
    // acc_q is always 0 in IDLE and HOLD, so a beat taken in HOLD starts
    // a fresh packet without any extra gating.
    pkt_par  = acc_q ^ beat_par ^ ODD_BIT;
    pkt_err  = chk_en & (pkt_par != in_par);

    state_d     = state_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_par_d   = out_par_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;

    // Result consumed: fall back to IDLE unless a new beat overrides below.
    if ((state_q == HOLD) && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end

    if (accept) begin
      if (in_last) begin
        out_par_d   = pkt_par;
        out_err_d   = pkt_err;
        out_valid_d = 1'b1;
        acc_d       = 1'b0;
        state_d     = HOLD;
        if (pkt_err && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
      end else begin
        acc_d       = acc_q ^ beat_par;
        out_valid_d = 1'b0;
        state_d     = ACCUM;
      end
    end

    if (clr_cnt) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_par_q   <= 1'b0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_par_q   <= out_par_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_par   = out_par_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_parity_stream.sv
// Bench for parity_stream: an even-parity 8-bit-counter instance and an
// odd-parity 2-bit-counter instance share one stimulus stream.
module tb_parity_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last, in_par, chk_en, out_ready, clr_cnt;
  logic [7:0] in_data;
  logic       in_ready0, in_ready1, out_valid0, out_valid1;
  logic       out_par0, out_par1, out_err0, out_err1;
  logic [7:0] err_cnt0;
  logic [1:0] err_cnt1;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending flag, held results, counters, beats of the open packet.
  bit         m_valid, m_par0, m_par1, m_err0, m_err1;
  int         m_cnt0, m_cnt1;
  logic [7:0] pkt[$];

  always #5 clk = ~clk;

  parity_stream #(.DATA_W(8), .ODD(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_last(in_last), .in_par(in_par), .chk_en(chk_en),
    .out_valid(out_valid0), .out_ready(out_ready), .out_par(out_par0),
    .out_err(out_err0), .err_cnt(err_cnt0), .clr_cnt(clr_cnt)
  );

  parity_stream #(.DATA_W(8), .ODD(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_last(in_last), .in_par(in_par), .chk_en(chk_en),
    .out_valid(out_valid1), .out_ready(out_ready), .out_par(out_par1),
    .out_err(out_err1), .err_cnt(err_cnt1), .clr_cnt(clr_cnt)
  );

  function automatic void model_reset();
    m_valid = 0; m_par0 = 0; m_par1 = 0; m_err0 = 0; m_err1 = 0;
    m_cnt0 = 0; m_cnt1 = 0;
    pkt.delete();
  endfunction

  task automatic drive(input logic v, input logic l, input logic [7:0] d,
                       input logic p, input logic c, input logic r, input logic k);
    in_valid = v; in_last = l; in_data = d; in_par = p; chk_en = c;
    out_ready = r; clr_cnt = k;
  endtask

  // One clock edge; the model advances using the inputs presented to that edge.
  task automatic tick();
    bit rdy, acc;
    int ones;
    rdy = !m_valid || out_ready;
    acc = in_valid && rdy;
    @(posedge clk);
    #1;
    if (m_valid && out_ready) m_valid = 0;
    if (acc) begin
      pkt.push_back(in_data);
      if (in_last) begin
        ones = 0;
        foreach (pkt[i]) for (int b = 0; b < 8; b++) ones += int'(pkt[i][b]);
        m_par0 = (ones % 2) == 1;
        m_par1 = !m_par0;
        m_err0 = chk_en && (m_par0 != in_par);
        m_err1 = chk_en && (m_par1 != in_par);
        if (m_err0 && m_cnt0 < 255) m_cnt0++;
        if (m_err1 && m_cnt1 < 3) m_cnt1++;
        m_valid = 1;
        pkt.delete();
      end
    end
    if (clr_cnt) begin
      m_cnt0 = 0;
      m_cnt1 = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0, 0, 1, 0);
    model_reset();
    #2;
    checks++;
    if ({out_valid0, out_par0, out_err0, err_cnt0, in_ready0} !== 12'h001) begin
      failures++;
      $display("FAIL reset_state0 got=%h exp=001", {out_valid0, out_par0, out_err0, err_cnt0, in_ready0});
    end
    checks++;
    if ({out_valid1, out_par1, out_err1, err_cnt1, in_ready1} !== 6'h01) begin
      failures++;
      $display("FAIL reset_state1 got=%h exp=01", {out_valid1, out_par1, out_err1, err_cnt1, in_ready1});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    drive(1, 1, 8'hA5, 0, 1, 1, 0);
    tick();
    checks++;
    if ({out_valid0, out_par0, out_err0, err_cnt0} !== {3'b100, 8'd0}) begin
      failures++;
      $display("FAIL single_a5 got v=%b p=%b e=%b c=%0d exp v=1 p=0 e=0 c=0", out_valid0, out_par0, out_err0, err_cnt0);
    end
    checks++;
    if ({out_valid1, out_par1, out_err1, err_cnt1} !== {3'b111, 2'd1}) begin
      failures++;
      $display("FAIL single_a5_odd got v=%b p=%b e=%b c=%0d exp v=1 p=1 e=1 c=1", out_valid1, out_par1, out_err1, err_cnt1);
    end
    drive(0, 0, 8'h00, 1, 1, 1, 0);
    tick();
    checks++;
    if ({out_valid0, out_par0, out_valid1, out_par1} !== 4'b0001) begin
      failures++;
      $display("FAIL consume_hold got=%b exp=0001", {out_valid0, out_par0, out_valid1, out_par1});
    end
  endtask

  task automatic test_multi();
    drive(1, 0, 8'h01, 1, 1, 1, 0); tick();
    drive(1, 0, 8'h03, 1, 1, 1, 0); tick();
    checks++;
    if (out_valid0 !== 1'b0) begin
      failures++;
      $display("FAIL mid_packet_valid got=%b exp=0", out_valid0);
    end
    drive(1, 1, 8'h07, 0, 0, 1, 0); tick();
    checks++;
    if ({out_valid0, out_par0, out_err0, out_par1, out_err1} !== 5'b10010) begin
      failures++;
      $display("FAIL multi_beat got=%b exp=10010", {out_valid0, out_par0, out_err0, out_par1, out_err1});
    end
  endtask

  task automatic test_mismatch();
    drive(1, 1, 8'h01, 0, 1, 1, 0); tick();
    checks++;
    if ({out_valid0, out_par0, out_err0, err_cnt0} !== {3'b111, 8'd1}) begin
      failures++;
      $display("FAIL mismatch got v=%b p=%b e=%b c=%0d exp v=1 p=1 e=1 c=1", out_valid0, out_par0, out_err0, err_cnt0);
    end
    drive(1, 1, 8'h01, 0, 0, 1, 0); tick();
    checks++;
    if ({out_valid0, out_par0, out_err0, err_cnt0} !== {3'b110, 8'd1}) begin
      failures++;
      $display("FAIL mismatch_nochk got v=%b p=%b e=%b c=%0d exp v=1 p=1 e=0 c=1", out_valid0, out_par0, out_err0, err_cnt0);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 8'hFF, 1, 1, 0, 0);
      #1;
      checks++;
      if ({in_ready0, in_ready1} !== 2'b00) begin
        failures++;
        $display("FAIL stall_ready cyc=%0d got=%b exp=00", i, {in_ready0, in_ready1});
      end
      tick();
      checks++;
      if ({out_valid0, out_par0, out_err0, err_cnt0} !== {3'b110, 8'd1}) begin
        failures++;
        $display("FAIL stall_stable cyc=%0d got v=%b p=%b e=%b c=%0d exp v=1 p=1 e=0 c=1", i, out_valid0, out_par0, out_err0, err_cnt0);
      end
    end
    drive(1, 1, 8'h03, 0, 0, 1, 0);
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin
      failures++;
      $display("FAIL release_ready got=%b exp=1", in_ready0);
    end
    tick();
    checks++;
    if ({out_valid0, out_par0, out_valid1, out_par1} !== 4'b1011) begin
      failures++;
      $display("FAIL no_bubble got=%b exp=1011", {out_valid0, out_par0, out_valid1, out_par1});
    end
    drive(0, 0, 8'h00, 0, 0, 1, 0); tick();
    checks++;
    if ({out_valid0, out_par0, out_valid1, out_par1} !== 4'b0001) begin
      failures++;
      $display("FAIL hold_after_consume got=%b exp=0001", {out_valid0, out_par0, out_valid1, out_par1});
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 8'h01, 0, 0, 1, 0); tick();
    drive(1, 0, 8'h01, 0, 0, 1, 0); tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({out_valid0, out_par0, out_err0, err_cnt0, in_ready0} !== 12'h001) begin
      failures++;
      $display("FAIL async_reset0 got=%h exp=001", {out_valid0, out_par0, out_err0, err_cnt0, in_ready0});
    end
    checks++;
    if ({out_valid1, out_par1, out_err1, err_cnt1, in_ready1} !== 6'h01) begin
      failures++;
      $display("FAIL async_reset1 got=%h exp=01", {out_valid1, out_par1, out_err1, err_cnt1, in_ready1});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 8'h01, 0, 0, 1, 0); tick();
    checks++;
    if ({out_valid0, out_par0, out_valid1, out_par1} !== 4'b1110) begin
      failures++;
      $display("FAIL post_reset_beat got=%b exp=1110", {out_valid0, out_par0, out_valid1, out_par1});
    end
  endtask

  task automatic test_saturation();
    drive(0, 0, 8'h00, 0, 0, 1, 1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 8'h00, 0, 1, 1, 0); tick();
      checks++;
      if ({err_cnt1, out_err1} !== {2'((i + 1 > 3) ? 3 : i + 1), 1'b1}) begin
        failures++;
        $display("FAIL sat_count pkt=%0d got c=%0d e=%b exp c=%0d e=1", i, err_cnt1, out_err1, (i + 1 > 3) ? 3 : i + 1);
      end
    end
    checks++;
    if (err_cnt0 !== 8'd0) begin
      failures++;
      $display("FAIL even_no_err got=%0d exp=0", err_cnt0);
    end
    drive(1, 1, 8'h00, 0, 1, 1, 1); tick();
    checks++;
    if ({err_cnt1, out_err1, out_valid1} !== 4'b0011) begin
      failures++;
      $display("FAIL clr_priority got c=%0d e=%b v=%b exp c=0 e=1 v=1", err_cnt1, out_err1, out_valid1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) == 0),
            8'($urandom), logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 24) == 0));
      #1;
      checks++;
      if ({in_ready0, in_ready1} !== {2{!m_valid || out_ready}}) begin
        failures++;
        $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, {in_ready0, in_ready1}, {2{!m_valid || out_ready}});
      end
      tick();
      checks++;
      if ({out_valid0, out_par0, out_err0, err_cnt0} !== {m_valid, m_par0, m_err0, 8'(m_cnt0)}) begin
        failures++;
        $display("FAIL rnd_even n=%0d got v=%b p=%b e=%b c=%0d exp v=%b p=%b e=%b c=%0d",
                 n, out_valid0, out_par0, out_err0, err_cnt0, m_valid, m_par0, m_err0, m_cnt0);
      end
      checks++;
      if ({out_valid1, out_par1, out_err1, err_cnt1} !== {m_valid, m_par1, m_err1, 2'(m_cnt1)}) begin
        failures++;
        $display("FAIL rnd_odd n=%0d got v=%b p=%b e=%b c=%0d exp v=%b p=%b e=%b c=%0d",
                 n, out_valid1, out_par1, out_err1, err_cnt1, m_valid, m_par1, m_err1, m_cnt1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_mismatch();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_stream.md
PARITY_STREAM -- requirements
Module: parity_stream

Interface
REQ-001 Parameter DATA_W, default 8, width of each data beat (>=1).
REQ-002 Parameter ODD, default 0, parity mode: 0 = even, 1 = odd.
REQ-003 Parameter CNT_W, default 8, error-counter width (>=1).
REQ-004 The design SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.
REQ-005 Ports SHALL be:
 clk  in  1  clock, rising edge
 rst_n  in  1  async active-low reset
 in_valid  in  1  beat offered
 in_ready  out  1  beat acceptable
 in_data  in  DATA_W  beat payload
 in_last  in  1  final beat of packet
 in_par  in  1  expected parity, sampled with last beat
 chk_en  in  1  enable checking, sampled with last beat
 out_valid  out  1  result available
 out_ready  in  1  result consumed
 out_par  out  1  computed packet parity
 out_err  out  1  parity mismatch for this packet
 err_cnt  out  CNT_W  saturating mismatch count
 clr_cnt  in  1  synchronous counter clear

Function
REQ-006 A beat SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1.
REQ-007 The FSM SHALL have states IDLE (accumulator 0), ACCUM (mid-packet) and HOLD (result pending).
REQ-008 in_ready SHALL be 1 in IDLE and ACCUM, and SHALL equal out_ready in HOLD.
REQ-009 Each accepted non-last beat SHALL XOR the reduction-XOR of in_data into the accumulator; the state SHALL be ACCUM afterwards.
REQ-010 An accepted last beat SHALL register out_par = acc ^ (^in_data) ^ ODD, register out_err = chk_en & (out_par != in_par), set out_valid=1 on the next cycle, clear the accumulator, and enter HOLD.
REQ-011 Latency from the last-beat acceptance edge to out_valid=1 SHALL be exactly one cycle.
REQ-012 In HOLD, out_valid, out_par and out_err SHALL stay stable while out_ready=0.
REQ-013 In HOLD with out_ready=1 and no beat accepted, the FSM SHALL drop out_valid and go to IDLE.
REQ-014 In HOLD with out_ready=1, a beat accepted in the same cycle SHALL start a new packet from a zero accumulator. A non-last beat SHALL move the FSM to ACCUM with out_valid=0. A last beat SHALL keep HOLD and load the new result with out_valid=1, so back-to-back single-beat packets complete at one per cycle.
REQ-015 out_par and out_err SHALL hold their last values while out_valid=0.
REQ-016 err_cnt SHALL increment by 1 on each last-beat acceptance that produces out_err=1, and SHALL saturate at 2^CNT_W-1.
REQ-017 clr_cnt=1 SHALL set err_cnt to 0 on the next edge, taking priority over a simultaneous increment.
REQ-018 in_par and chk_en SHALL be ignored on non-last beats. With chk_en=0, out_err=0 and err_cnt is unchanged.
REQ-019 A single-beat packet (in_last=1 on the first beat) SHALL be legal and handled per REQ-010.

Reset
REQ-020 rst_n=0 SHALL immediately, without waiting for a clock edge, force: state IDLE, accumulator 0, out_valid=0, out_par=0, out_err=0, err_cnt=0. in_ready SHALL then be 1.
REQ-021 Reset mid-packet SHALL discard the partial packet; the next packet's parity SHALL NOT depend on pre-reset beats.
REQ-022 On release of rst_n, the first beat SHALL be acceptable at the first rising edge after rst_n goes high.

Verification (DATA_W=8, ODD=0, CNT_W=8 unless stated)
REQ-023 Single beat 8'hA5, last=1, in_par=0, chk_en=1 -> next cycle out_valid=1, out_par=0, out_err=0, err_cnt=0.
REQ-024 Beats 8'h01, 8'h03, 8'h07 (last on third) -> out_par=0; same stimulus with ODD=1 -> out_par=1.
REQ-025 Beat 8'h01, last=1, in_par=0, chk_en=1 -> out_par=1, out_err=1, err_cnt=1. Repeat with chk_en=0 -> out_err=0, err_cnt stays 1.
REQ-026 out_ready=0 for 5 cycles after a result, in_valid=1 throughout -> out_valid/out_par stable, in_ready=0, no beat accepted. Then out_ready=1 with last beat 8'h03 -> next result out_par=0 loaded with no bubble.
REQ-027 CNT_W=2, 5 mismatching packets -> err_cnt=3. clr_cnt=1 on the same edge as a sixth mismatch -> err_cnt=0.
REQ-028 Two beats 8'h01, 8'h01 (no last), then rst_n=0 for 2 cycles -> all outputs 0. Then single beat 8'h01, last=1 -> out_par=1.
